// File: rtl/alu_wb_stage_pkg.sv
// Shared types for the ALU write-back stage:
// opcodes, branch conditions and the write-back entry layout.
package alu_wb_stage_pkg;

    localparam int DATA_WIDTH     = 36;
    localparam int ALU_OP_WIDTH   = 3;
    localparam int REG_ADDR_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLL  = 3'd5,
        ALU_SRL  = 3'd6,
        ALU_SUBS = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_EQ = 2'b01,
        COND_NE = 2'b10,
        COND_LT = 2'b11
    } cond_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wr_en;
    } wb_entry_t;

    localparam int WB_ENTRY_WIDTH = $bits(wb_entry_t);

    function automatic logic eval_cond(
        input logic [1:0] cond,
        input logic       z,
        input logic       n
    );
        logic res;
        case (cond)
            COND_AL: res = 1'b1;
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_LT: res = n;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// Execute-to-write-back bundle: upstream handshake,
// downstream register-file port, flags and branch query.
interface alu_wb_stage_if;
    import alu_wb_stage_pkg::*;

    logic                      i_valid;
    logic                      o_ready;
    logic [DATA_WIDTH-1:0]     i_alu_result;
    logic [ALU_OP_WIDTH-1:0]   i_alu_op;
    logic [REG_ADDR_WIDTH-1:0] i_rd;
    logic                      i_wr_en;
    logic                      o_valid;
    logic                      i_ready;
    logic [DATA_WIDTH-1:0]     o_result;
    logic [REG_ADDR_WIDTH-1:0] o_rd;
    logic                      o_wr_en;
    logic                      o_flag_z;
    logic                      o_flag_n;
    logic [1:0]                i_cond;
    logic                      o_cond_true;

    // Stage side
    modport slave (
        input  i_valid, i_alu_result, i_alu_op, i_rd, i_wr_en,
        input  i_ready, i_cond,
        output o_ready, o_valid, o_result, o_rd, o_wr_en,
        output o_flag_z, o_flag_n, o_cond_true
    );

    // Environment side (execute stage + register file)
    modport master (
        output i_valid, i_alu_result, i_alu_op, i_rd, i_wr_en,
        output i_ready, i_cond,
        input  o_ready, o_valid, o_result, o_rd, o_wr_en,
        input  o_flag_z, o_flag_n, o_cond_true
    );

endinterface

// File: rtl/alu_wb_stage_skid_buffer.sv
// Generic 2-entry valid/ready register: main drives the output,
// skid catches one entry on a stall so in_ready can be a flop.
module alu_wb_stage_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_q,   main_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_q,   skid_d;
    logic             accept;
    logic             drain;

    assign accept      = in_valid_i & ~skid_v_q;
    assign drain       = ~main_v_q | out_ready_i;
    assign in_ready_o  = ~skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

    // Next state: refill main from skid first to keep order,
    // otherwise from the input; park input in skid on a stall.
    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (drain) begin
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_v_d = 1'b1;
                main_d   = in_data_i;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = in_data_i;
        end
    end

    // Storage registers; reset empties both entries
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_v_q <= 1'b0;
            main_q   <= '0;
            skid_v_q <= 1'b0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_q   <= main_d;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: buffered result path, N/Z flag
// register written by SUBS, and branch condition evaluation.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    alu_wb_stage_if.slave bus
);

    wb_entry_t in_entry;
    wb_entry_t out_entry;
    logic      in_ready;
    logic      out_valid;
    logic      accept;
    logic      flag_z_q, flag_z_d;
    logic      flag_n_q, flag_n_d;

    assign in_entry.result = bus.i_alu_result;
    assign in_entry.rd     = bus.i_rd;
    assign in_entry.wr_en  = bus.i_wr_en;

    alu_wb_stage_skid_buffer #(
        .WIDTH(WB_ENTRY_WIDTH)
    ) u_skid (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .in_valid_i  (bus.i_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid),
        .out_ready_i (bus.i_ready),
        .out_data_o  (out_entry)
    );

    assign accept = bus.i_valid & in_ready;

    // Flags follow a SUBS at accept time, regardless of stalls
    always_comb begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        if (accept && (bus.i_alu_op == ALU_SUBS)) begin
            flag_z_d = (bus.i_alu_result == '0);
            flag_n_d = bus.i_alu_result[DATA_WIDTH-1];
        end
    end

    // Committed flag register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign bus.o_ready     = in_ready;
    assign bus.o_valid     = out_valid;
    assign bus.o_result    = out_entry.result;
    assign bus.o_rd        = out_entry.rd;
    assign bus.o_wr_en     = out_valid & bus.i_ready & out_entry.wr_en;
    assign bus.o_flag_z    = flag_z_q;
    assign bus.o_flag_n    = flag_n_q;
    assign bus.o_cond_true = eval_cond(bus.i_cond, flag_z_q, flag_n_q);

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage.
// Inputs change 1ns after the rising edge; checks follow.
module tb_alu_wb_stage;
    import alu_wb_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_wb_stage_if bus ();

    alu_wb_stage dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [35:0] res,
                         input logic [2:0] op, input logic [3:0] rd,
                         input logic wr);
        bus.i_valid      = v;
        bus.i_alu_result = res;
        bus.i_alu_op     = op;
        bus.i_rd         = rd;
        bus.i_wr_en      = wr;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 36'h0, ALU_ADD, 4'h0, 1'b0);
        bus.i_ready = 1'b1;
        bus.i_cond  = COND_AL;
        #3;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_result", bus.o_result, 0);
        chk("rst_rd", bus.o_rd, 0);
        chk("rst_z", bus.o_flag_z, 0);
        chk("rst_n_flag", bus.o_flag_n, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Streaming 1..4, no bubbles
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 36'(k), ALU_ADD, 4'(k), 1'b1);
            tick();
            chk("str_valid", bus.o_valid, 1);
            chk("str_result", bus.o_result, 64'(k));
            chk("str_rd", bus.o_rd, 64'(k));
            chk("str_wr", bus.o_wr_en, 1);
            chk("str_ready", bus.o_ready, 1);
        end
        drive(1'b0, 36'h0, ALU_ADD, 4'h0, 1'b0);
        tick();
        chk("str_idle", bus.o_valid, 0);

        // Back-pressure: A held, B in skid, C held off
        bus.i_ready = 1'b0;
        drive(1'b1, 36'hA, ALU_ADD, 4'h1, 1'b1);
        tick();
        chk("bp_a_res", bus.o_result, 36'hA);
        chk("bp_a_ready", bus.o_ready, 1);
        chk("bp_a_wr", bus.o_wr_en, 0);
        drive(1'b1, 36'hB, ALU_ADD, 4'h2, 1'b1);
        tick();
        chk("bp_b_res", bus.o_result, 36'hA);
        chk("bp_b_ready", bus.o_ready, 0);
        drive(1'b1, 36'hC, ALU_ADD, 4'h3, 1'b1);
        tick();
        chk("bp_c_res", bus.o_result, 36'hA);
        chk("bp_c_ready", bus.o_ready, 0);
        bus.i_ready = 1'b1;
        #1;
        chk("bp_rel_wr", bus.o_wr_en, 1);
        tick();
        chk("bp_out_b", bus.o_result, 36'hB);
        chk("bp_out_b_rd", bus.o_rd, 2);
        chk("bp_rdy_back", bus.o_ready, 1);
        tick();
        chk("bp_out_c", bus.o_result, 36'hC);
        chk("bp_out_c_v", bus.o_valid, 1);
        drive(1'b0, 36'h0, ALU_ADD, 4'h0, 1'b0);
        tick();
        chk("bp_idle", bus.o_valid, 0);

        // Reset mid-stream with both entries full
        bus.i_ready = 1'b0;
        drive(1'b1, 36'hD, ALU_ADD, 4'h4, 1'b1);
        tick();
        drive(1'b1, 36'h0, ALU_SUBS, 4'h5, 1'b1);
        tick();
        chk("mr_full", bus.o_ready, 0);
        chk("mr_z_set", bus.o_flag_z, 1);
        drive(1'b0, 36'h0, ALU_ADD, 4'h0, 1'b0);
        bus.i_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", bus.o_valid, 0);
        chk("mr_ready", bus.o_ready, 1);
        chk("mr_z", bus.o_flag_z, 0);
        chk("mr_wr", bus.o_wr_en, 0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 36'hF, ALU_ADD, 4'h6, 1'b1);
        tick();
        chk("mr_first", bus.o_result, 36'hF);
        chk("mr_first_v", bus.o_valid, 1);

        // Flags: SUBS 0, ADD with msb, SUBS negative
        drive(1'b1, 36'h0, ALU_SUBS, 4'h1, 1'b1);
        tick();
        chk("fl_z1", bus.o_flag_z, 1);
        chk("fl_n0", bus.o_flag_n, 0);
        bus.i_cond = COND_EQ;
        #1;
        chk("fl_eq1", bus.o_cond_true, 1);
        drive(1'b1, 36'h8_0000_0000, ALU_ADD, 4'h1, 1'b1);
        tick();
        chk("fl_add_z", bus.o_flag_z, 1);
        chk("fl_add_n", bus.o_flag_n, 0);
        drive(1'b1, 36'h8_0000_0000, ALU_SUBS, 4'h1, 1'b1);
        #1;
        chk("fl_nobypass", bus.o_cond_true, 1);
        tick();
        chk("fl_z0", bus.o_flag_z, 0);
        chk("fl_n1", bus.o_flag_n, 1);
        bus.i_cond = COND_LT;
        #1;
        chk("fl_lt", bus.o_cond_true, 1);
        bus.i_cond = COND_EQ;
        #1;
        chk("fl_eq0", bus.o_cond_true, 0);
        bus.i_cond = COND_NE;
        #1;
        chk("fl_ne1", bus.o_cond_true, 1);
        drive(1'b0, 36'h0, ALU_ADD, 4'h0, 1'b0);
        tick();

        // Flag timing under stall
        bus.i_ready = 1'b0;
        drive(1'b1, 36'h0, ALU_SUBS, 4'h7, 1'b1);
        tick();
        chk("st_z", bus.o_flag_z, 1);
        chk("st_valid", bus.o_valid, 1);
        chk("st_wr", bus.o_wr_en, 0);
        chk("st_ne", bus.o_cond_true, 0);
        drive(1'b0, 36'h0, ALU_ADD, 4'h0, 1'b0);
        bus.i_ready = 1'b1;
        tick();
        chk("st_drain", bus.o_valid, 0);

        // Non-writing entry keeps its slot
        drive(1'b1, 36'h55, ALU_ADD, 4'h5, 1'b0);
        tick();
        chk("nw_valid", bus.o_valid, 1);
        chk("nw_rd", bus.o_rd, 5);
        chk("nw_wr", bus.o_wr_en, 0);
        drive(1'b1, 36'h66, ALU_ADD, 4'h6, 1'b1);
        tick();
        chk("nw_next", bus.o_result, 36'h66);
        chk("nw_next_wr", bus.o_wr_en, 1);
        drive(1'b0, 36'h0, ALU_ADD, 4'h0, 1'b0);
        tick();
        chk("nw_idle", bus.o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
